reduce_gate_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed-fan-in combinational gate cells (and2..and8, nand2..nand8, or2/or8, nor2, xor2).
- One instance reduces an N_IN-bit vector with a runtime-selected function: AND, OR, XOR, NAND, NOR or XNOR.
- The reduction is a registered tree carrying a valid/ready handshake.
- Includes a saturating count of high results, used as a rare-node activation monitor by the trojan-detection benches.

---
 rtl/gate_pkg.sv | 52 +++++
 rtl/reduce_level.sv | 49 ++++
 rtl/reduce_gate_pipe.sv | 119 +++++++++++
 tb/tb_reduce_gate_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the pipelined reduction gate: op encoding,
// base reduction functions and the elaboration helpers that size the tree.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {FN_AND, FN_OR, FN_XOR} fn_e;

    typedef struct packed {
        fn_e  fn;
        logic inv;
    } op_t;

    // Pad bit that leaves the reduction unchanged.
    function automatic logic identity(fn_e fn);
        return (fn == FN_AND);
    endfunction

    function automatic int clog_base(int n, int g);
        int l;
        int span;
        l    = 0;
        span = 1;
        while (span < n) begin
            span = span * g;
            l++;
        end
        return l;
    endfunction

    function automatic int ipow(int g, int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * g;
        return r;
    endfunction

    // Bit offset of tree stage k in the flat bus holding every stage,
    // widest (padded input) first down to the single result bit.
    function automatic int tree_off(int g, int lvl, int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o = o + ipow(g, lvl - j);
        return o;
    endfunction

endpackage

// File: rtl/reduce_level.sv
// One registered level of the reduction tree: each GROUP-bit slice is reduced
// to one bit and held with its valid bit until the next level can take it.
module reduce_level
    import gate_pkg::*;
#(
    parameter int GROUP = 4,
    parameter int W_IN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [W_IN-1:0]       in_data,
    input  fn_e                   in_fn,
    input  logic                  in_inv,
    output logic                  load,
    input  logic                  nxt_load,
    output logic                  out_valid,
    output logic [W_IN/GROUP-1:0] out_data
);

    localparam int W_OUT = W_IN / GROUP;

    logic [W_OUT-1:0] red;

    // Empty slot or a consumer that drains this cycle: safe to overwrite.
    assign load = !out_valid || nxt_load;

    always_comb begin
        red = '0;
        for (int i = 0; i < W_OUT; i++) begin
            case (in_fn)
                FN_OR:   red[i] = |in_data[i*GROUP +: GROUP];
                FN_XOR:  red[i] = ^in_data[i*GROUP +: GROUP];
                default: red[i] = &in_data[i*GROUP +: GROUP];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= red ^ {W_OUT{in_inv}};
        end
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Pipelined N_IN-bit reduction (AND/OR/XOR and inverses) with valid/ready flow,
// sticky reserved-op flag and a saturating count of high results.
module reduce_gate_pipe
    import gate_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int GROUP = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             op_err,
    output logic [CNT_W-1:0] hi_cnt,
    input  logic             cnt_clr
);

    localparam int LVL = clog_base(N_IN, GROUP);
    localparam int PW  = ipow(GROUP, LVL);
    localparam int TW  = tree_off(GROUP, LVL, LVL + 1);

    logic [TW-1:0]       tree;
    logic [LVL:0]        vld_pipe;
    logic [LVL:0]        ld;
    op_t  [LVL-1:0]      op_pipe;
    op_t                 in_dec;
    logic                rsv_op;
    logic [PW-1:0]       pad;
    logic                xfer_hi;

    always_comb begin
        in_dec.fn  = FN_AND;
        in_dec.inv = 1'b0;
        rsv_op     = 1'b0;
        case (in_op)
            OP_AND:  in_dec.fn = FN_AND;
            OP_OR:   in_dec.fn = FN_OR;
            OP_XOR:  in_dec.fn = FN_XOR;
            OP_NAND: in_dec.inv = 1'b1;
            OP_NOR: begin
                in_dec.fn  = FN_OR;
                in_dec.inv = 1'b1;
            end
            OP_XNOR: begin
                in_dec.fn  = FN_XOR;
                in_dec.inv = 1'b1;
            end
            default: rsv_op = 1'b1;
        endcase
        pad            = {PW{identity(in_dec.fn)}};
        pad[N_IN-1:0]  = in_data;
    end

    assign tree[PW-1:0] = pad;
    assign vld_pipe[0]  = in_valid;
    assign op_pipe[0]   = in_dec;
    assign ld[LVL]      = out_ready;
    assign in_ready     = ld[0];

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int  OI   = tree_off(GROUP, LVL, k);
        localparam int  WI   = ipow(GROUP, LVL - k);
        localparam int  OO   = OI + WI;
        localparam int  WO   = WI / GROUP;
        localparam bit  LAST = (k == LVL - 1);

        // Inversion is applied once, as the final level registers its bit.
        reduce_level #(
            .GROUP (GROUP),
            .W_IN  (WI)
        ) u_lvl (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_pipe[k]),
            .in_data   (tree[OI +: WI]),
            .in_fn     (op_pipe[k].fn),
            .in_inv    (LAST ? op_pipe[k].inv : 1'b0),
            .load      (ld[k]),
            .nxt_load  (ld[k+1]),
            .out_valid (vld_pipe[k+1]),
            .out_data  (tree[OO +: WO])
        );

        if (!LAST) begin : g_op
            op_t op_q;
            always_ff @(posedge clk) begin
                if (ld[k] && vld_pipe[k]) op_q <= op_pipe[k];
            end
            assign op_pipe[k+1] = op_q;
        end
    end

    assign out_valid = vld_pipe[LVL];
    assign out_y     = tree[TW-1];
    assign xfer_hi   = out_valid && out_ready && out_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt <= '0;
            op_err <= 1'b0;
        end else begin
            if (cnt_clr)
                hi_cnt <= '0;
            else if (xfer_hi && (hi_cnt != {CNT_W{1'b1}}))
                hi_cnt <= hi_cnt + 1'b1;
            if (in_valid && in_ready && rsv_op)
                op_err <= 1'b1;
            else if (cnt_clr)
                op_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe: op table, streaming, backpressure,
// counter saturation/clear, reserved op, mid-flight reset and a 3-level tree.
module tb_reduce_gate_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_y, op_err, cnt_clr;
    logic [7:0] in_data;
    logic [2:0] in_op;
    logic [3:0] hi_cnt;

    logic       d5_in_valid, d5_in_ready, d5_out_valid, d5_out_ready, d5_out_y;
    logic       d5_op_err, d5_cnt_clr;
    logic [4:0] d5_in_data;
    logic [2:0] d5_in_op;
    logic [3:0] d5_hi_cnt;

    int n_run  = 0;
    int n_fail = 0;

    logic [2:0] exp_tab [6];
    logic [7:0] pat [3];
    logic       bp_exp [3];
    int         got, seen;
    logic       acc;

    always #5 clk = ~clk;

    reduce_gate_pipe #(.N_IN(8), .GROUP(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .op_err(op_err),
        .hi_cnt(hi_cnt), .cnt_clr(cnt_clr)
    );

    reduce_gate_pipe #(.N_IN(5), .GROUP(2), .CNT_W(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .in_data(d5_in_data), .in_op(d5_in_op), .out_valid(d5_out_valid),
        .out_ready(d5_out_ready), .out_y(d5_out_y), .op_err(d5_op_err),
        .hi_cnt(d5_hi_cnt), .cnt_clr(d5_cnt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic model(input logic [2:0] op, input logic [7:0] d);
        logic r;
        case (op)
            3'd1, 3'd4: r = |d;
            3'd2, 3'd5: r = ^d;
            default:    r = &d;
        endcase
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) r = ~r;
        return r;
    endfunction

    task automatic send_one(input string tag, input logic [2:0] op, input logic [7:0] d,
                            input logic exp_y);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_data = d;
        @(negedge clk);
        chk({tag, " rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({tag, " lat"}, lat, 2);
        chk({tag, " y"}, out_y, exp_y);
    endtask

    task automatic send5(input string tag, input logic [2:0] op, input logic [4:0] d,
                         input logic exp_y);
        int lat;
        @(posedge clk); #1;
        d5_in_valid = 1'b1; d5_in_op = op; d5_in_data = d;
        @(negedge clk);
        chk({tag, " rdy"}, d5_in_ready, 1);
        @(posedge clk); #1;
        d5_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d5_out_valid && lat < 10);
        chk({tag, " lat"}, lat, 3);
        chk({tag, " y"}, d5_out_y, exp_y);
    endtask

    task automatic stream(input int n, input bit all_hi);
        logic q[$];
        int   cnt;
        cnt = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    in_valid = 1'b1;
                    in_op    = all_hi ? 3'd0 : 3'($urandom_range(0, 5));
                    in_data  = all_hi ? 8'hFF : 8'($urandom);
                    @(negedge clk);
                    chk("stream rdy", in_ready, 1);
                    q.push_back(model(in_op, in_data));
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < n + 10; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) chk("stream extra", 1, 0);
                        else               chk("stream y", out_y, q.pop_front());
                        cnt++;
                    end
                end
            end
        join
        chk("stream cnt", cnt, n);
    endtask

    initial begin
        exp_tab = '{3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110};
        pat     = '{8'hFF, 8'h00, 8'hFE};
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        d5_in_valid = 1'b0; d5_in_op = '0; d5_in_data = '0; d5_out_ready = 1'b1; d5_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_y", out_y, 0);
        chk("rst op_err", op_err, 0);
        chk("rst hi_cnt", hi_cnt, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst d5 out_valid", d5_out_valid, 0);

        for (int op = 0; op < 6; op++)
            for (int p = 0; p < 3; p++)
                send_one($sformatf("op%0d p%0d", op, p), 3'(op), pat[p], exp_tab[op][2-p]);

        stream(10, 1'b0);

        // backpressure: A=AND FF(1), B=OR 00(0), C=XOR 01(1)
        bp_exp = '{1'b1, 1'b0, 1'b1};
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_data = 8'hFF;
        @(posedge clk); #1;
        in_op = 3'd1; in_data = 8'h00;
        @(posedge clk); #1;
        in_op = 3'd2; in_data = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            chk("bp out_y hold", out_y, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (got < 3) chk("bp drain y", out_y, bp_exp[got]);
                else         chk("bp drain extra", 1, 0);
                got++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        chk("bp drain cnt", got, 3);
        chk("bp in_valid dropped", in_valid, 0);

        // counter saturation and clear priority
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr hi_cnt", hi_cnt, 0);
        stream(20, 1'b1);
        chk("sat hi_cnt", hi_cnt, 15);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 3'd0; in_data = 8'hFF;
        @(posedge clk); #1 in_valid = 1'b0;
        got = 0;
        do begin
            @(negedge clk);
            got++;
        end while (!out_valid && got < 10);
        chk("clrx out_valid", out_valid, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("clrx hi_cnt", hi_cnt, 0);

        // reserved op
        chk("err before", op_err, 0);
        send_one("rsv", 3'd7, 8'h0F, 1'b0);
        chk("rsv op_err", op_err, 1);
        send_one("rsv next", 3'd0, 8'hFF, 1'b1);
        chk("rsv sticky", op_err, 1);
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("err clr", op_err, 0);
        chk("err clr hi_cnt", hi_cnt, 0);

        // mid-flight reset
        send_one("pre", 3'd0, 8'hFF, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 3'd0; in_data = 8'hFF;
        @(negedge clk);
        chk("pre hi_cnt", hi_cnt, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("pre-rst out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("mrst out_valid", out_valid, 0);
        chk("mrst hi_cnt", hi_cnt, 0);
        chk("mrst in_ready", in_ready, 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mrst ghost beats", seen, 0);

        // N_IN=5, GROUP=2: padded to 8, three levels
        send5("d5 or", 3'd1, 5'b00000, 1'b0);
        send5("d5 and", 3'd0, 5'b11111, 1'b1);
        send5("d5 xor", 3'd2, 5'b10110, 1'b1);
        send5("d5 nand", 3'd3, 5'b10111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
